// File: rtl/xif_fp_issuer.sv
// Core-side FP coprocessor issuer: allocates transaction IDs, issues to the FPU over valid/ready,
// retires out-of-order results by ID, writes integer results back and force-retires stuck IDs.
module xif_fp_issuer #(
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    input  logic [XLEN-1:0]       rs1_data,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [31:0]           issue_instr,
    output logic [X_ID_WIDTH-1:0] issue_id,
    output logic [XLEN-1:0]       issue_rs1,
    input  logic                  result_valid,
    input  logic [X_ID_WIDTH-1:0] result_id,
    input  logic [XLEN-1:0]       result_data,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic [X_ID_WIDTH:0]   outstanding,
    output logic                  spurious_err,
    output logic                  timeout_err,
    output logic [X_ID_WIDTH-1:0] err_id
);

    localparam int unsigned NUM_IDS = 1 << X_ID_WIDTH;
    localparam int unsigned AGE_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_W   = X_ID_WIDTH + 1;

    logic [NUM_IDS-1:0]    alloc_q;
    logic [NUM_IDS-1:0]    issued_q;
    logic [NUM_IDS-1:0]    wr_x_q;
    logic [4:0]            rd_q  [NUM_IDS];
    logic [AGE_W-1:0]      age_q [NUM_IDS];
    logic [X_ID_WIDTH-1:0] next_id;

    logic                  accept;
    logic                  issue_hs;
    logic                  result_hit;
    logic                  spurious;
    logic                  wr_x_new;
    logic [NUM_IDS-1:0]    timeout_mask;
    logic [NUM_IDS-1:0]    retire_mask;
    logic [CNT_W-1:0]      retire_cnt;
    logic [X_ID_WIDTH-1:0] timeout_id;
    logic                  timeout_any;

    assign issue_hs    = issue_valid && issue_ready;
    assign instr_ready = (!issue_valid || issue_ready)
                         && (outstanding < CNT_W'(MAX_OUTSTANDING))
                         && !alloc_q[next_id];
    assign accept      = instr_valid && instr_ready;
    assign result_hit  = result_valid && alloc_q[result_id] && issued_q[result_id];
    assign spurious    = result_valid && !result_hit;
    assign wr_x_new    = (instr[6:0] == 7'b1010011)
                         && ((instr[31:27] == 5'b10100) || (instr[31:27] == 5'b11000)
                             || (instr[31:27] == 5'b11100));
    assign timeout_any = |timeout_mask;

    // Retire set for this cycle: a same-cycle result beats the timeout on that ID.
    always_comb begin
        timeout_mask = '0;
        retire_mask  = '0;
        retire_cnt   = '0;
        timeout_id   = '0;
        for (int i = int'(NUM_IDS) - 1; i >= 0; i--) begin
            timeout_mask[i] = issued_q[i] && (age_q[i] == AGE_W'(TIMEOUT_CYCLES - 1))
                              && !(result_hit && (result_id == X_ID_WIDTH'(i)));
            retire_mask[i]  = timeout_mask[i] || (result_hit && (result_id == X_ID_WIDTH'(i)));
            retire_cnt      = retire_cnt + CNT_W'(retire_mask[i]);
            if (timeout_mask[i]) begin
                timeout_id = X_ID_WIDTH'(i);
            end
        end
    end

    // Scoreboard; accept, handshake and retire never target the same entry in one cycle.
    always_ff @(posedge ck) begin
        if (rst) begin
            alloc_q  <= '0;
            issued_q <= '0;
            wr_x_q   <= '0;
            for (int i = 0; i < int'(NUM_IDS); i++) begin
                rd_q[i]  <= '0;
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_IDS); i++) begin
                if (retire_mask[i]) begin
                    alloc_q[i]  <= 1'b0;
                    issued_q[i] <= 1'b0;
                end else if (issue_hs && (issue_id == X_ID_WIDTH'(i))) begin
                    issued_q[i] <= 1'b1;
                    age_q[i]    <= '0;
                end else if (issued_q[i]) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
                if (accept && (next_id == X_ID_WIDTH'(i))) begin
                    alloc_q[i]  <= 1'b1;
                    issued_q[i] <= 1'b0;
                    wr_x_q[i]   <= wr_x_new;
                    rd_q[i]     <= instr[11:7];
                end
            end
        end
    end

    // Issue register, ID allocator and occupancy count.
    always_ff @(posedge ck) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_instr <= '0;
            issue_id    <= '0;
            issue_rs1   <= '0;
            next_id     <= '0;
            outstanding <= '0;
        end else begin
            if (accept) begin
                issue_valid <= 1'b1;
                issue_instr <= instr;
                issue_id    <= next_id;
                issue_rs1   <= rs1_data;
                next_id     <= next_id + X_ID_WIDTH'(1);
            end else if (issue_hs) begin
                issue_valid <= 1'b0;
            end
            outstanding <= outstanding + CNT_W'(accept) - retire_cnt;
        end
    end

    // Writeback pulse and sticky error reporting; the spurious ID wins err_id.
    always_ff @(posedge ck) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            spurious_err <= 1'b0;
            timeout_err  <= 1'b0;
            err_id       <= '0;
        end else begin
            wb_valid <= result_hit && wr_x_q[result_id];
            if (result_hit && wr_x_q[result_id]) begin
                wb_rd   <= rd_q[result_id];
                wb_data <= result_data;
            end
            if (spurious) begin
                spurious_err <= 1'b1;
                err_id       <= result_id;
            end else if (timeout_any) begin
                err_id <= timeout_id;
            end
            if (timeout_any) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xif_fp_issuer.sv
// Randomized and directed bench for xif_fp_issuer against a per-ID transaction model
// built from timestamps, a pending-issue queue and allocation counts.
module tb_xif_fp_issuer;

    localparam int NUM_IDS = 16;
    localparam int MAXO    = 8;
    localparam int TO      = 64;

    logic        ck;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [3:0]  issue_id;
    logic [31:0] issue_rs1;
    logic        result_valid;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  outstanding;
    logic        spurious_err;
    logic        timeout_err;
    logic [3:0]  err_id;

    xif_fp_issuer dut (
        .ck(ck), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .rs1_data(rs1_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .issue_id(issue_id), .issue_rs1(issue_rs1),
        .result_valid(result_valid), .result_id(result_id), .result_data(result_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .outstanding(outstanding), .spurious_err(spurious_err), .timeout_err(timeout_err),
        .err_id(err_id)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    typedef struct {
        logic [31:0] ins;
        logic [31:0] rs1;
        int          id;
    } pend_t;

    int    n_cmp  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    bit    m_alloc  [NUM_IDS];
    bit    m_issued [NUM_IDS];
    bit    m_wrx    [NUM_IDS];
    int    m_rd     [NUM_IDS];
    int    m_issue_t[NUM_IDS];
    int    m_next_id;
    pend_t pend_q[$];
    bit    m_wb_valid;
    int    m_wb_rd;
    logic [31:0] m_wb_data;
    bit    m_spur;
    bit    m_tout;
    int    m_err_id;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit wr_x_of(input logic [31:0] w);
        return (w[6:0] == 7'b1010011) && (w[31:27] inside {5'b10100, 5'b11000, 5'b11100});
    endfunction

    function automatic int n_alloc();
        int n = 0;
        foreach (m_alloc[i]) n += int'(m_alloc[i]);
        return n;
    endfunction

    function automatic void model_clear();
        foreach (m_alloc[i]) begin
            m_alloc[i] = 0; m_issued[i] = 0; m_wrx[i] = 0; m_rd[i] = 0; m_issue_t[i] = 0;
        end
        pend_q.delete();
        m_next_id = 0; m_wb_valid = 0; m_wb_rd = 0; m_wb_data = '0;
        m_spur = 0; m_tout = 0; m_err_id = 0;
    endfunction

    task automatic check_outputs();
        check_eq("issue_valid", 32'(issue_valid), 32'(pend_q.size() != 0));
        if (pend_q.size() != 0) begin
            check_eq("issue_instr", issue_instr, pend_q[0].ins);
            check_eq("issue_id", 32'(issue_id), 32'(pend_q[0].id));
            check_eq("issue_rs1", issue_rs1, pend_q[0].rs1);
        end
        check_eq("wb_valid", 32'(wb_valid), 32'(m_wb_valid));
        if (m_wb_valid) begin
            check_eq("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
            check_eq("wb_data", wb_data, m_wb_data);
        end
        check_eq("outstanding", 32'(outstanding), 32'(n_alloc()));
        check_eq("spurious_err", 32'(spurious_err), 32'(m_spur));
        check_eq("timeout_err", 32'(timeout_err), 32'(m_tout));
        check_eq("err_id", 32'(err_id), 32'(m_err_id));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 0; instr = '0; rs1_data = '0; issue_ready = 0;
        result_valid = 0; result_id = '0; result_data = '0;
        repeat (2) @(posedge ck);
        #1;
        rst = 1'b0;
        model_clear();
        check_outputs();
    endtask

    // One clock cycle: apply inputs, check the ready, advance the model, check registered outputs.
    task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] r1, input bit ir,
                        input bit rv, input logic [3:0] rid, input logic [31:0] rdat);
        bit    exp_ready;
        bit    hit;
        bit    to[NUM_IDS];
        int    lowest_to;
        pend_t p;
        instr_valid = iv; instr = ins; rs1_data = r1; issue_ready = ir;
        result_valid = rv; result_id = rid; result_data = rdat;
        #1;
        exp_ready = (pend_q.size() == 0 || ir) && (n_alloc() < MAXO) && !m_alloc[m_next_id];
        check_eq("instr_ready", 32'(instr_ready), 32'(exp_ready));

        hit = rv && m_alloc[rid] && m_issued[rid];
        lowest_to = -1;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            to[i] = m_issued[i] && (cyc - m_issue_t[i] == TO) && !(hit && int'(rid) == i);
            if (to[i]) lowest_to = i;
        end
        m_wb_valid = 0;
        if (hit) begin
            if (m_wrx[rid]) begin
                m_wb_valid = 1; m_wb_rd = m_rd[rid]; m_wb_data = rdat;
            end
            m_alloc[rid] = 0; m_issued[rid] = 0;
        end
        foreach (to[i]) if (to[i]) begin m_alloc[i] = 0; m_issued[i] = 0; end
        if (lowest_to >= 0) m_tout = 1;
        if (rv && !hit) begin
            m_spur = 1; m_err_id = int'(rid);
        end else if (lowest_to >= 0) begin
            m_err_id = lowest_to;
        end
        if (pend_q.size() != 0 && ir) begin
            p = pend_q.pop_front();
            m_issued[p.id] = 1; m_issue_t[p.id] = cyc;
        end
        if (iv && exp_ready) begin
            p.ins = ins; p.rs1 = r1; p.id = m_next_id;
            pend_q.push_back(p);
            m_alloc[m_next_id] = 1; m_issued[m_next_id] = 0;
            m_wrx[m_next_id] = wr_x_of(ins); m_rd[m_next_id] = int'(ins[11:7]);
            m_next_id = (m_next_id + 1) % NUM_IDS;
        end
        @(posedge ck);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input bit ir);
        step(0, '0, '0, ir, 0, '0, '0);
    endtask

    function automatic int pick_live(input int exclude);
        int c[$];
        foreach (m_issued[i]) if (m_issued[i] && i != exclude) c.push_back(i);
        if (c.size() == 0) return -1;
        return c[$urandom_range(c.size() - 1)];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(1) == 1) begin
            w[6:0] = 7'b1010011;
            case ($urandom_range(2))
                0:       w[31:27] = 5'b10100;
                1:       w[31:27] = 5'b11000;
                default: w[31:27] = 5'b11100;
            endcase
        end
        return w;
    endfunction

    // Random cycle; result IDs mostly target live transactions, sometimes arbitrary ones.
    task automatic rand_step(input int p_iv, input int p_ir, input int p_rv, input int excl);
        int  live;
        bit  rv;
        logic [3:0] rid;
        live = pick_live(excl);
        rv   = ($urandom_range(99) < p_rv);
        rid  = 4'($urandom_range(15));
        if (live >= 0 && $urandom_range(9) < 8) rid = 4'(live);
        if (excl >= 0 && rid == 4'(excl)) rv = 0;
        step($urandom_range(99) < p_iv, rand_instr(), $urandom, $urandom_range(99) < p_ir,
             rv, rid, $urandom);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        do_reset();
        check_eq("reset_issue_instr", issue_instr, 32'h0);
        check_eq("reset_wb_data", wb_data, 32'h0);

        // fcvt.w.s x5 round trip
        step(1, 32'hC00072D3, 32'h0000_1234, 1, 0, '0, '0);
        check_eq("t1_issue_id", 32'(issue_id), 32'd0);
        idle(1);
        step(0, '0, '0, 1, 1, 4'd0, 32'h7);
        check_eq("t1_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("t1_wb_rd", 32'(wb_rd), 32'd5);
        check_eq("t1_wb_data", wb_data, 32'h7);
        idle(1);
        check_eq("t1_outstanding", 32'(outstanding), 32'd0);

        // eight fadd.s fill the scoreboard, then all time out without writeback
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 32'h0000_0053 | (32'(i + 1) << 7), 32'(i), 1, 0, '0, '0);
        step(1, 32'h0000_0053, '0, 1, 0, '0, '0);
        check_eq("t2_ready_full", 32'(instr_ready), 32'd0);
        check_eq("t2_outstanding", 32'(outstanding), 32'd8);
        for (int i = 0; i < TO + 4; i++) idle(1);
        check_eq("t2_timeout", 32'(timeout_err), 32'd1);

        // stalled issue port
        do_reset();
        step(1, 32'hC00080D3, 32'hAAAA_0001, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) step(1, 32'hC0009153, 32'hBBBB_0002, 0, 0, '0, '0);
        check_eq("t3_held_instr", issue_instr, 32'hC00080D3);
        step(1, 32'hC0009153, 32'hBBBB_0002, 1, 0, '0, '0);
        check_eq("t3_next_id", 32'(issue_id), 32'd1);
        idle(1);

        // out-of-order results 2,0,1
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 32'hC0000053 | (32'(10 + i) << 7), '0, 1, 0, '0, '0);
        idle(1);
        step(0, '0, '0, 1, 1, 4'd2, 32'h22);
        check_eq("t4_rd_id2", 32'(wb_rd), 32'd12);
        step(0, '0, '0, 1, 1, 4'd0, 32'h00);
        step(0, '0, '0, 1, 1, 4'd1, 32'h11);
        check_eq("t4_data_id1", wb_data, 32'h11);

        // unallocated result ID
        step(0, '0, '0, 1, 1, 4'd9, 32'hDEAD);
        check_eq("t5_spur", 32'(spurious_err), 32'd1);
        check_eq("t5_err_id", 32'(err_id), 32'd9);

        // reset mid-flight, then a late result
        do_reset();
        step(1, 32'hA0000053, '0, 1, 0, '0, '0);
        step(1, 32'hA0000053, '0, 1, 0, '0, '0);
        idle(1);
        do_reset();
        step(0, '0, '0, 1, 1, 4'd1, 32'h5);
        check_eq("t6_late_spur", 32'(spurious_err), 32'd1);

        // id0 withheld while next_id wraps, then it times out
        do_reset();
        step(1, 32'hE0000053, '0, 1, 0, '0, '0);
        idle(1);
        for (int i = 0; i < TO + 16; i++) rand_step(100, 100, 100, 0);
        check_eq("t7_timeout", 32'(timeout_err), 32'd1);

        // randomized phases with varied handshake and result rates
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            int p_iv, p_ir, p_rv;
            p_iv = $urandom_range(30, 100);
            p_ir = $urandom_range(20, 100);
            p_rv = (ph % 3 == 2) ? $urandom_range(0, 3) : $urandom_range(20, 90);
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(999) == 0) do_reset();
                else rand_step(p_iv, p_ir, p_rv, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/xif_fp_issuer.md
Name: xif_fp_issuer

Overview:
Core-side initiator for the FP coprocessor interface: accepts FP instructions from the core pipeline, assigns transaction IDs, and issues them to the FPU over a valid/ready handshake. It tracks outstanding IDs in a scoreboard and matches returning results by ID, in any order. Results destined for the integer register file are written back to the core, and stuck transactions are flagged by timeout. It sits between the core decode stage and the FPU model wrapper.

Parameters:
X_ID_WIDTH, 4, transaction ID width
MAX_OUTSTANDING, 8, max in-flight transactions (must be <= 2**X_ID_WIDTH)
XLEN, 32, integer data width
TIMEOUT_CYCLES, 64, cycles an issued ID may wait for its result before being force-retired

Ports:
ck  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
instr_valid  in  1  core offers an instruction
instr_ready  out  1  issuer accepts instruction this cycle
instr  in  32  FP instruction word
rs1_data  in  XLEN  integer operand for the instruction
issue_valid  out  1  issue request to FPU
issue_ready  in  1  FPU accepts issue (fpu_ready)
issue_instr  out  32  registered instruction
issue_id  out  X_ID_WIDTH  assigned ID
issue_rs1  out  XLEN  registered operand
result_valid  in  1  FPU returns a result
result_id  in  X_ID_WIDTH  ID of the result
result_data  in  XLEN  result value (data_toXreg)
wb_valid  out  1  one-cycle integer writeback pulse
wb_rd  out  5  destination x-register
wb_data  out  XLEN  writeback value
outstanding  out  X_ID_WIDTH+1  number of allocated IDs
spurious_err  out  1  sticky: result for unallocated or unissued ID
timeout_err  out  1  sticky: an issued ID timed out
err_id  out  X_ID_WIDTH  ID of the most recent error

Behaviour:
- Reset: all outputs 0, scoreboard cleared, next_id=0, issue register empty. Reset mid-transaction drops all in-flight state; late results arriving after reset count as spurious.
- Scoreboard entry per ID: alloc, issued, wr_x, rd[4:0], age counter.
- wr_x = (instr[6:0]==7'b1010011) && instr[31:27] in {10100, 11000, 11100}; rd = instr[11:7].
- instr_ready = (issue register empty OR issue handshake completing this cycle) AND outstanding<MAX_OUTSTANDING AND !alloc[next_id]. Combinational; it never depends on instr_valid.
- Accept (instr_valid && instr_ready): the issue register loads instr/rs1/next_id and issue_valid=1 next cycle. The entry is allocated with issued=0, and next_id increments mod 2**X_ID_WIDTH. IDs are never skipped; a busy next_id stalls acceptance.
- Issue handshake: issue_valid and payload stay stable until issue_ready. On issue_valid && issue_ready the entry gets issued=1 and age=0. Back-to-back issue at one per cycle is supported.
- Result: always accepted (no result_ready).
  - If alloc[result_id] && issued[result_id]: the entry frees next cycle. If wr_x, then wb_valid=1, wb_rd=rd, wb_data=result_data, one cycle after result_valid.
  - Otherwise: set spurious_err, err_id=result_id, drop the result.
- Age: each issued entry increments age per cycle. When age reaches TIMEOUT_CYCLES-1 with no result, the entry frees, timeout_err is set, err_id is captured, and no writeback occurs. If a result and a timeout hit the same ID in the same cycle, the result wins.
- outstanding: +1 on accept, -1 per retire (result or timeout). Accept and retire in the same cycle leave it unchanged. A result and a timeout on different IDs in the same cycle are both handled (-2, plus an accept if one occurs).
- If two errors occur in the same cycle, err_id holds the spurious ID. Sticky flags clear only on rst.
- Latency: instr accept -> issue_valid at 1 cycle; result_valid -> wb_valid at 1 cycle.

Test Plan:
- Reset, then issue fcvt.w.s x5 (instr=32'hC00072D3), issue_ready=1, result id0 data=32'h7 two cycles later -> issue_id=0; wb_valid one cycle later with wb_rd=5, wb_data=7; outstanding back to 0.
- Issue 8 fadd.s (wr_x=0) with no results -> instr_ready=0 after the 8th accept, outstanding=8, wb_valid never asserted.
- Hold issue_ready=0 for 5 cycles with instr_valid=1 -> issue_valid and issue_instr/issue_id stay stable; instr_ready drops once the register is full. Release -> issue completes, the next instruction is accepted that same cycle.
- Results return out of order for ids 2,0,1 with data 0x22,0x00,0x11 -> wb sequence of rd/data pairs matches per ID; no errors.
- result_valid with unallocated id 9 -> spurious_err=1, err_id=9, no wb_valid, outstanding unchanged.
- Issue id 0 and withhold its result for 64 cycles -> timeout_err=1, err_id=0, outstanding=0. Wrap next_id from 15 to 0 while id0 is still alloc -> instr_ready=0 until it retires.
